booth_dadda_mul_pipe: RTL and testbench

Parametrised, pipelined radix-4 Booth multiplier with Dadda-tree reduction and final carry-propagate adder, wrapped in a valid/ready streaming interface. It supports signed and unsigned operands on a per-transaction basis and carries a user tag alongside each product. It is the generalised successor of the fixed-width Booth/Dadda datapath and is used as the multiplier core of the filter and MAC datapaths.

---
 rtl/booth_dadda_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_booth_dadda_mul_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_dadda_mul_pipe.sv
// booth_dadda_mul_pipe: elastic 3-stage radix-4 Booth multiplier with Dadda reduction and tag sideband
module booth_dadda_mul_pipe #(
  parameter int NBIT = 12,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBIT-1:0]   in_a,
  input  logic [NBIT-1:0]   in_b,
  input  logic              in_signed,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NBIT-1:0] out_p,
  output logic [TAGW-1:0]   out_tag
);
  localparam int N2  = NBIT + 2;
  localparam int M   = NBIT + 3;
  localparam int NPP = NBIT / 2 + 1;
  localparam int W   = 2 * NBIT;
  localparam int MH  = NPP + 3;
  localparam int NS  = 10;

  logic v1, v2, v3, ld1, ld2, ld3;
  logic [NBIT-1:0] a1, b1;
  logic s1;
  logic [TAGW-1:0] t1, t2;
  logic [W-1:0] row0, row1, q0, q1;

  // Sum of the -2^(msb) offsets left behind by inverting each partial product's sign bit
  function automatic logic [W-1:0] corr();
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < NPP; i++)
      if (M - 1 + 2 * i < W) c = c - (W'(1) << (M - 1 + 2 * i));
    return c;
  endfunction

  // Dadda height sequence 2,3,4,6,9,13,...
  function automatic int dseq(input int k);
    int d;
    d = 2;
    for (int j = 0; j < k; j++) d = d * 3 / 2;
    return d;
  endfunction

  assign ld3       = v2 & (!v3 | out_ready);
  assign ld2       = v1 & (!v2 | ld3);
  assign in_ready  = !v1 | ld2;
  assign ld1       = in_valid & in_ready;
  assign out_valid = v3;

  // Booth recoding into a column bit matrix, then Dadda stages down to two rows
  always_comb begin : tree
    logic [N2-1:0] ax, bx;
    logic [N2:0] bb;
    logic [2:0] g;
    logic [M-1:0] mag, pp;
    logic [W-1:0] k;
    logic [MH-1:0] m [W];
    logic [MH-1:0] nm [W];
    int h [W];
    int nh [W];
    int idx, tot, d;
    logic sm, cy;
    ax = s1 ? {{2{a1[NBIT-1]}}, a1} : {2'b00, a1};
    bx = s1 ? {{2{b1[NBIT-1]}}, b1} : {2'b00, b1};
    bb = {bx, 1'b0};
    g = '0;
    mag = '0;
    pp = '0;
    idx = 0;
    tot = 0;
    d = 0;
    sm = 1'b0;
    cy = 1'b0;
    k = corr();
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < W; c++) begin
      m[c] = '0;
      nm[c] = '0;
      h[c] = 0;
      nh[c] = 0;
    end
    for (int c = 0; c < W; c++)
      if (k[c]) begin
        m[c][h[c]] = 1'b1;
        h[c]++;
      end
    for (int i = 0; i < NPP; i++) begin
      g = bb[2*i +: 3];
      mag = (g[1] ^ g[0]) ? {ax[N2-1], ax} :
            ((g[2] & ~g[1] & ~g[0]) | (~g[2] & g[1] & g[0])) ? {ax, 1'b0} : '0;
      pp = g[2] ? ~mag : mag;
      pp[M-1] = ~pp[M-1];
      m[2*i][h[2*i]] = g[2];
      h[2*i]++;
      for (int j = 0; j < M; j++)
        if (2 * i + j < W) begin
          m[2*i+j][h[2*i+j]] = pp[j];
          h[2*i+j]++;
        end
    end
    for (int s = NS - 1; s >= 0; s--) begin
      d = dseq(s);
      for (int c = 0; c < W; c++) begin
        nm[c] = '0;
        nh[c] = 0;
      end
      for (int c = 0; c < W; c++) begin
        idx = 0;
        for (int r = 0; r < MH; r++) begin
          tot = h[c] - idx + nh[c];
          if (tot > d && h[c] - idx >= 2) begin
            if (tot == d + 1 || h[c] - idx == 2) begin
              sm = m[c][idx] ^ m[c][idx+1];
              cy = m[c][idx] & m[c][idx+1];
              idx += 2;
            end else begin
              sm = m[c][idx] ^ m[c][idx+1] ^ m[c][idx+2];
              cy = (m[c][idx] & m[c][idx+1]) | (m[c][idx+2] & (m[c][idx] ^ m[c][idx+1]));
              idx += 3;
            end
            nm[c][nh[c]] = sm;
            nh[c]++;
            if (c + 1 < W) begin
              nm[c+1][nh[c+1]] = cy;
              nh[c+1]++;
            end
          end
        end
        for (int r = 0; r < MH; r++)
          if (r >= idx && r < h[c]) begin
            nm[c][nh[c]] = m[c][r];
            nh[c]++;
          end
      end
      for (int c = 0; c < W; c++) begin
        m[c] = nm[c];
        h[c] = nh[c];
      end
    end
    for (int c = 0; c < W; c++) begin
      row0[c] = m[c][0];
      row1[c] = m[c][1];
    end
  end

  // Stage occupancy: fill on handover from upstream, empty when downstream takes the data
  always_ff @(posedge clk or posedge rst)
    if (rst) {v1, v2, v3} <= '0;
    else begin
      v1 <= ld1 | (v1 & !ld2);
      v2 <= ld2 | (v2 & !ld3);
      v3 <= ld3 | (v3 & !out_ready);
    end

  // S1 operand capture
  always_ff @(posedge clk or posedge rst)
    if (rst) {a1, b1, s1, t1} <= '0;
    else if (ld1) {a1, b1, s1, t1} <= {in_a, in_b, in_signed, in_tag};

  // S2 holds the two reduced rows
  always_ff @(posedge clk or posedge rst)
    if (rst) {q0, q1, t2} <= '0;
    else if (ld2) {q0, q1, t2} <= {row0, row1, t1};

  // S3 final carry-propagate add
  always_ff @(posedge clk or posedge rst)
    if (rst) {out_p, out_tag} <= '0;
    else if (ld3) {out_p, out_tag} <= {q0 + q1, t2};
endmodule

// File: tb/tb_booth_dadda_mul_pipe.sv
// tb_booth_dadda_mul_pipe: directed and scoreboarded checks of the pipelined Booth multiplier
module tb_booth_dadda_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_signed = 1'b0, out_valid, out_ready = 1'b0;
  logic [11:0] in_a = '0, in_b = '0;
  logic [3:0] in_tag = '0, out_tag;
  logic [23:0] out_p;
  logic q_valid = 1'b0, q_ready, q_signed = 1'b0, q_ovalid, q_oready = 1'b0;
  logic [3:0] q_a = '0, q_b = '0, q_tag = '0, q_otag;
  logic [7:0] q_p;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_dadda_mul_pipe #(.NBIT(12), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag));

  booth_dadda_mul_pipe #(.NBIT(4), .TAGW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(q_valid), .in_ready(q_ready), .in_a(q_a), .in_b(q_b),
    .in_signed(q_signed), .in_tag(q_tag), .out_valid(q_ovalid), .out_ready(q_oready),
    .out_p(q_p), .out_tag(q_otag));

  function automatic logic [23:0] ref12(input logic [11:0] a, input logic [11:0] b, input logic s);
    logic [23:0] xa, xb;
    xa = s ? {{12{a[11]}}, a} : {12'h000, a};
    xb = s ? {{12{b[11]}}, b} : {12'h000, b};
    return xa * xb;
  endfunction

  function automatic logic [7:0] ref8(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] xa, xb;
    xa = s ? {{4{a[3]}}, a} : {4'h0, a};
    xb = s ? {{4{b[3]}}, b} : {4'h0, b};
    return xa * xb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++;
    if (out_p !== 24'h0) begin miscompares++; $display("FAIL reset_out_p got=%h exp=000000", out_p); end
    vectors++;
    if (out_tag !== 4'h0) begin miscompares++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++;
    if (q_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid4 got=%b exp=0", q_ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] av[8], bv[8];
    logic sv[8];
    logic [23:0] ev[8];
    int k;
    av = '{12'h800, 12'h7FF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    bv = '{12'h800, 12'h800, 12'hFFF, 12'hFFF, 12'hFFF, 12'h001, 12'h001, 12'h001};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{24'h400000, 24'hC00800, 24'h000000, 24'h000001, 24'hFFE001, 24'hFFFFFF, 24'h000FFF, 24'hFFFFFF};
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      in_valid = c < 8;
      if (c < 8) begin
        in_a = av[c];
        in_b = bv[c];
        in_signed = sv[c];
        in_tag = 4'(c + 1);
      end
      tick();
      k = c - 2;
      vectors++;
      if (k >= 0 && k < 8) begin
        if (out_valid !== 1'b1 || out_p !== ev[k] || out_tag !== 4'(k + 1)) begin
          miscompares++;
          $display("FAIL b2b_%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h", k, out_valid, out_p, out_tag, ev[k], 4'(k + 1));
        end
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_idle_cycle%0d got v=%b exp v=0", c, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] av[5], bv[5];
    logic sv[5];
    logic [23:0] ev[5];
    int idx, got;
    logic held;
    logic [23:0] hp;
    logic [3:0] ht;
    av = '{12'h003, 12'hFF9, 12'h064, 12'h800, 12'hFFF};
    bv = '{12'h005, 12'h009, 12'hF9C, 12'h002, 12'hFFE};
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ev = '{24'h00000F, 24'hFFFFC1, 24'hFFD8F0, 24'h001000, 24'hFFD002};
    idx = 0;
    got = 0;
    held = 1'b0;
    hp = '0;
    ht = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      in_valid = idx < 5;
      if (idx < 5) begin
        in_a = av[idx];
        in_b = bv[idx];
        in_signed = sv[idx];
        in_tag = 4'(idx + 8);
      end
      out_ready = (c >= 6) && (c % 2 == 1);
      #1;
      if (c == 3 || c == 5) begin
        vectors++;
        if (in_ready !== 1'b0 || idx != 3) begin
          miscompares++;
          $display("FAIL bp_full_cycle%0d got in_ready=%b accepted=%0d exp in_ready=0 accepted=3", c, in_ready, idx);
        end
      end
      if (c == 7) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      end
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || out_p !== hp || out_tag !== ht) begin
          miscompares++;
          $display("FAIL bp_hold got v=%b p=%h t=%h exp v=1 p=%h t=%h", out_valid, out_p, out_tag, hp, ht);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (out_p !== ev[got] || out_tag !== 4'(got + 8)) begin
          miscompares++;
          $display("FAIL bp_result_%0d got p=%h t=%h exp p=%h t=%h", got, out_p, out_tag, ev[got], 4'(got + 8));
        end
        got++;
      end
      held = out_valid & !out_ready;
      hp = out_p;
      ht = out_tag;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 5) begin miscompares++; $display("FAIL bp_count got=%0d exp=5", got); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = 12'(k + 2);
      in_b = 12'h003;
      in_signed = 1'b0;
      in_tag = 4'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_loaded got=%b exp=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_async_clear got=%b exp=0", out_valid); end
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale_cycle%0d got=%b exp=0", c, out_valid); end
    end
    in_valid = 1'b1;
    in_a = 12'h005;
    in_b = 12'h007;
    in_signed = 1'b1;
    in_tag = 4'hA;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_early got=%b exp=0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_p !== 24'h000023 || out_tag !== 4'hA) begin
      miscompares++;
      $display("FAIL rmid_first got v=%b p=%h t=%h exp v=1 p=000023 t=a", out_valid, out_p, out_tag);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [27:0] q[$];
    logic [27:0] e;
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_a = 12'($urandom);
      in_b = 12'($urandom);
      in_signed = 1'($urandom);
      in_tag = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (in_valid && in_ready) q.push_back({in_tag, ref12(in_a, in_b, in_signed)});
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra got p=%h t=%h exp none", out_p, out_tag);
        end else begin
          e = q.pop_front();
          if ({out_tag, out_p} !== e) begin
            miscompares++;
            $display("FAIL rand_result got t=%h p=%h exp t=%h p=%h", out_tag, out_p, e[27:24], e[23:0]);
          end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid) begin
        vectors++;
        e = q.pop_front();
        if ({out_tag, out_p} !== e) begin
          miscompares++;
          $display("FAIL rand_drain got t=%h p=%h exp t=%h p=%h", out_tag, out_p, e[27:24], e[23:0]);
        end
      end
      tick();
    end
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_lost got pending=%0d out_valid=%b exp pending=0 out_valid=0", q.size(), out_valid);
    end
  endtask

  task automatic test_exhaustive4();
    logic [11:0] q[$];
    logic [11:0] e;
    int v;
    v = 0;
    q_oready = 1'b1;
    for (int c = 0; c < 700 && (v < 512 || q.size() > 0); c++) begin
      q_valid = v < 512;
      q_signed = v[8];
      q_a = v[7:4];
      q_b = v[3:0];
      q_tag = v[3:0] ^ v[7:4];
      #1;
      if (q_valid && q_ready) begin
        q.push_back({q_tag, ref8(q_a, q_b, q_signed)});
        v++;
      end
      if (q_ovalid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL exh4_extra got p=%h exp none", q_p);
        end else begin
          e = q.pop_front();
          if ({q_otag, q_p} !== e) begin
            miscompares++;
            $display("FAIL exh4_result got t=%h p=%h exp t=%h p=%h", q_otag, q_p, e[11:8], e[7:0]);
          end
        end
      end
      tick();
    end
    q_valid = 1'b0;
    vectors++;
    if (v != 512 || q.size() != 0) begin
      miscompares++;
      $display("FAIL exh4_count got accepted=%0d pending=%0d exp accepted=512 pending=0", v, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    test_exhaustive4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
